// File: rtl/sram_pkg.sv
// Shared types and default geometry for the 32K x 8 asynchronous SRAM arbiter.
package sram_pkg;

  localparam int unsigned SRAM_ADDR_WIDTH = 15;
  localparam int unsigned SRAM_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    STROBE,
    HOLD
  } sram_state_e;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } sram_port_e;

endpackage

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and setup/strobe/hold sequencer for an async SRAM.
// Every SRAM pin and ack is a flop, so no request input reaches the pins combinationally.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = SRAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH    = SRAM_DATA_WIDTH,
  parameter int unsigned STROBE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic [ADDR_WIDTH-1:0] sram_address,
  output logic [DATA_WIDTH-1:0] sram_dout,
  input  logic [DATA_WIDTH-1:0] sram_din,
  output logic                  sram_drive,
  output logic                  sram_chip_enable_n,
  output logic                  sram_write_enable_n,
  output logic                  sram_output_enable_n
);

  localparam logic [3:0] STROBE_LOAD = 4'(STROBE_CYCLES - 1);

  sram_state_e           state_q, state_d;
  sram_port_e            port_q, port_d;
  sram_port_e            last_grant_q, last_grant_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic [DATA_WIDTH-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic                  ce_n_q, ce_n_d, we_n_q, we_n_d, oe_n_q, oe_n_d;
  logic                  drive_q, drive_d;
  logic                  grant_b;

  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;
    grant_b      = 1'b0;

    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          grant_b = b_req && (!a_req || (last_grant_q == PORT_A));
          port_d  = grant_b ? PORT_B : PORT_A;
          we_d    = grant_b ? b_we : a_we;
          addr_d  = grant_b ? b_addr : a_addr;
          wdata_d = grant_b ? b_wdata : a_wdata;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = STROBE_LOAD;
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          if (!we_q) begin
            if (port_q == PORT_A) a_rdata_d = sram_din;
            else                  b_rdata_d = sram_din;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      HOLD: begin
        last_grant_d = port_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Pins are decoded from the next state so the registered copy lines up with the phase.
    ce_n_d  = (state_d == IDLE);
    we_n_d  = !((state_d == STROBE) && we_d);
    oe_n_d  = !((state_d == STROBE) && !we_d);
    drive_d = (state_d != IDLE) && we_d;
    a_ack_d = (state_d == HOLD) && (port_d == PORT_A);
    b_ack_d = (state_d == HOLD) && (port_d == PORT_B);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      port_q       <= PORT_A;
      last_grant_q <= PORT_B;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      a_ack_q      <= 1'b0;
      b_ack_q      <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
      ce_n_q       <= 1'b1;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      drive_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      a_ack_q      <= a_ack_d;
      b_ack_q      <= b_ack_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
      ce_n_q       <= ce_n_d;
      we_n_q       <= we_n_d;
      oe_n_q       <= oe_n_d;
      drive_q      <= drive_d;
    end
  end

  assign a_ack                = a_ack_q;
  assign b_ack                = b_ack_q;
  assign a_rdata              = a_rdata_q;
  assign b_rdata              = b_rdata_q;
  assign sram_address         = addr_q;
  assign sram_dout            = wdata_q;
  assign sram_drive           = drive_q;
  assign sram_chip_enable_n   = ce_n_q;
  assign sram_write_enable_n  = we_n_q;
  assign sram_output_enable_n = oe_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: three instances (STROBE_CYCLES 2, 1, 15), each on a behavioural SRAM.
module tb_sram_arbiter;
  import sram_pkg::*;

  localparam int unsigned NI = 3;
  localparam int unsigned AW = 15;
  localparam int unsigned DW = 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  logic          req   [NI][2];
  logic          wen   [NI][2];
  logic [AW-1:0] addr  [NI][2];
  logic [DW-1:0] wdata [NI][2];
  logic          ack   [NI][2];
  logic [DW-1:0] rdata [NI][2];
  logic [AW-1:0] s_addr  [NI];
  logic [DW-1:0] s_dout  [NI];
  logic [DW-1:0] s_din   [NI];
  logic          s_drive [NI];
  logic          ce_n    [NI];
  logic          we_n    [NI];
  logic          oe_n    [NI];

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return a[7:0] ^ {1'b0, a[14:8]} ^ 8'hA5;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_inst
    logic [DW-1:0] mem     [2**AW];
    bit            written [2**AW];

    sram_arbiter #(
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .STROBE_CYCLES(g == 0 ? 2 : (g == 1 ? 1 : 15))
    ) u_dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .a_req               (req[g][0]),
      .a_we                (wen[g][0]),
      .a_addr              (addr[g][0]),
      .a_wdata             (wdata[g][0]),
      .a_ack               (ack[g][0]),
      .a_rdata             (rdata[g][0]),
      .b_req               (req[g][1]),
      .b_we                (wen[g][1]),
      .b_addr              (addr[g][1]),
      .b_wdata             (wdata[g][1]),
      .b_ack               (ack[g][1]),
      .b_rdata             (rdata[g][1]),
      .sram_address        (s_addr[g]),
      .sram_dout           (s_dout[g]),
      .sram_din            (s_din[g]),
      .sram_drive          (s_drive[g]),
      .sram_chip_enable_n  (ce_n[g]),
      .sram_write_enable_n (we_n[g]),
      .sram_output_enable_n(oe_n[g])
    );

    // Pad plus SRAM: the SRAM drives whenever OE is low with WE high; unwritten bytes read as pat().
    assign s_din[g] = s_drive[g] ? s_dout[g] :
                      (!ce_n[g] && !oe_n[g] && we_n[g]) ?
                        (written[s_addr[g]] ? mem[s_addr[g]] : pat(s_addr[g])) : 'x;

    always @(posedge we_n[g]) begin
      if (!ce_n[g]) begin
        mem[s_addr[g]]     <= s_din[g];
        written[s_addr[g]] <= 1'b1;
      end
    end
  end

  int unsigned viol = 0;
  int unsigned ack_cnt [NI][2];
  int unsigned we_run  [NI];
  int unsigned we_len  [NI];
  int unsigned cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if ((!we_n[i] && !oe_n[i]) || (s_drive[i] && !oe_n[i]) || ((!we_n[i] || !oe_n[i]) && ce_n[i]))
        viol <= viol + 1;
      for (int p = 0; p < 2; p++)
        if (ack[i][p]) ack_cnt[i][p] <= ack_cnt[i][p] + 1;
      if (!we_n[i]) begin
        we_run[i] <= we_run[i] + 1;
      end else if (we_run[i] != 0) begin
        we_len[i] <= we_run[i];
        we_run[i] <= 0;
      end
    end
  end

  typedef struct packed {
    logic          we;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          exp_q [2][$];
  logic [DW-1:0] exp_mem [NI][2**AW];
  int unsigned   issued  [NI][2];
  int unsigned   order_log [$];
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Drives one request, waits (bounded) for its ack, then scores it against the queued expectation.
  task automatic do_txn(input int unsigned i, input int unsigned p, input logic w,
                        input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int unsigned exp_lat, input bit hold, output int unsigned ack_cyc);
    exp_t        e;
    int unsigned lat  = 1;
    bit          seen = 1'b0;
    e.we   = w;
    e.data = w ? d : exp_mem[i][a];
    if (w) exp_mem[i][a] = d;
    exp_q[p].push_back(e);
    issued[i][p]++;
    req[i][p]   = 1'b1;
    wen[i][p]   = w;
    addr[i][p]  = a;
    wdata[i][p] = d;
    while (!seen && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (ack[i][p]) seen = 1'b1;
    end
    ack_cyc = cyc;
    if (exp_q[p].size() != 0) e = exp_q[p].pop_front();
    if (!seen) begin
      check($sformatf("ack_timeout[%0d][%0d]", i, p), 32'd0, 32'd1);
    end else begin
      if (!e.we) check($sformatf("rdata[%0d][%0d]@%0h", i, p, a), 32'(rdata[i][p]), 32'(e.data));
      if (exp_lat != 0) check($sformatf("latency[%0d][%0d]", i, p), lat, exp_lat);
      order_log.push_back(p);
    end
    if (!hold) req[i][p] = 1'b0;
  endtask

  initial begin
    int unsigned c1, c2;
    for (int i = 0; i < NI; i++) begin
      for (int p = 0; p < 2; p++) begin
        req[i][p]   = 1'b0;
        wen[i][p]   = 1'b0;
        addr[i][p]  = '0;
        wdata[i][p] = '0;
      end
      for (int a = 0; a < 2**AW; a++) exp_mem[i][a] = pat(AW'(a));
    end

    #1 reset_n = 1'b0;
    #1;
    for (int i = 0; i < NI; i++) begin
      check("rst_ce_n",  32'(ce_n[i]),    32'd1);
      check("rst_we_n",  32'(we_n[i]),    32'd1);
      check("rst_oe_n",  32'(oe_n[i]),    32'd1);
      check("rst_drive", 32'(s_drive[i]), 32'd0);
      check("rst_addr",  32'(s_addr[i]),  32'd0);
      check("rst_dout",  32'(s_dout[i]),  32'd0);
      check("rst_ack",   32'({ack[i][0], ack[i][1]}),     32'd0);
      check("rst_rdata", 32'({rdata[i][0], rdata[i][1]}), 32'd0);
    end
    #10 reset_n = 1'b1;
    sync();

    // Simultaneous requests: A wins the first tie after reset, then strict alternation.
    order_log = {};
    fork
      begin
        for (int k = 0; k < 3; k++) do_txn(0, 0, 1'b0, AW'(16'h0010 + k), 8'h00, 0, 1'b0, c1);
      end
      begin
        for (int k = 0; k < 3; k++) do_txn(0, 1, 1'b0, AW'(16'h0020 + k), 8'h00, 0, 1'b0, c2);
      end
    join
    check("grant_count", order_log.size(), 6);
    for (int k = 0; k < 6 && k < order_log.size(); k++)
      check($sformatf("grant_order[%0d]", k), order_log[k], k % 2);
    sync();

    do_txn(0, 0, 1'b1, 15'h1234, 8'h5A, 5, 1'b0, c1);
    @(negedge clk);
    #1 check("we_low_len_sc2", we_len[0], 2);
    sync();
    do_txn(0, 0, 1'b0, 15'h1234, 8'h00, 5, 1'b0, c1);
    sync();

    // Held request: back-to-back A transactions one transaction period apart.
    do_txn(0, 0, 1'b1, 15'h0555, 8'hC3, 5, 1'b1, c1);
    do_txn(0, 0, 1'b0, 15'h0555, 8'h00, 0, 1'b0, c2);
    check("held_req_spacing", c2 - c1, 5);
    sync();

    fork
      begin
        logic [AW-1:0] a;
        logic          w;
        for (int k = 0; k < 100; k++) begin
          a = AW'($urandom_range(0, 31) * 2);
          w = 1'($urandom_range(0, 1));
          do_txn(0, 0, w, a, 8'($urandom), 0, 1'b0, c1);
          repeat ($urandom_range(0, 2)) sync();
        end
      end
      begin
        logic [AW-1:0] a;
        logic          w;
        for (int k = 0; k < 100; k++) begin
          a = AW'($urandom_range(0, 31) * 2 + 1);
          w = 1'($urandom_range(0, 1));
          do_txn(0, 1, w, a, 8'($urandom), 0, 1'b0, c2);
          repeat ($urandom_range(0, 2)) sync();
        end
      end
    join
    sync();

    for (int i = 1; i < NI; i++) begin
      int unsigned sc;
      sc = (i == 1) ? 1 : 15;
      do_txn(i, 0, 1'b1, 15'h7FFF, 8'hFF, sc + 3, 1'b0, c1);
      @(negedge clk);
      #1 check($sformatf("we_low_len_sc%0d", sc), we_len[i], sc);
      sync();
      do_txn(i, 0, 1'b0, 15'h7FFF, 8'h00, sc + 3, 1'b0, c1);
      sync();
    end

    // Reset during a B write strobe: pins must release before the next edge, no ack.
    req[0][1]   = 1'b1;
    wen[0][1]   = 1'b1;
    addr[0][1]  = 15'h0100;
    wdata[0][1] = 8'h33;
    for (int k = 0; k < 20 && we_n[0]; k++) sync();
    check("abort_in_strobe", 32'(we_n[0]), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("abort_we_n",  32'(we_n[0]),    32'd1);
    check("abort_oe_n",  32'(oe_n[0]),    32'd1);
    check("abort_ce_n",  32'(ce_n[0]),    32'd1);
    check("abort_drive", 32'(s_drive[0]), 32'd0);
    check("abort_rdata", 32'(rdata[0][0]), 32'd0);
    req[0][1] = 1'b0;
    repeat (2) sync();
    reset_n = 1'b1;
    sync();
    do_txn(0, 0, 1'b0, 15'h0200, 8'h00, 5, 1'b0, c1);
    repeat (3) sync();

    for (int i = 0; i < NI; i++)
      for (int p = 0; p < 2; p++)
        check($sformatf("ack_count[%0d][%0d]", i, p), ack_cnt[i][p], issued[i][p]);
    check("protocol_violations", viol, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
